// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the 16-bit MIPS datapath. Holds the
//               default register-file geometry, the hardwired zero register
//               and the word/address typedefs used by decode and writeback.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter
// Description : Pending-write counter for one architectural register.
//               Saturating up/down count of in-flight writes with a
//               synchronous flush, plus single-cycle overflow/underflow
//               pulses for the sticky scoreboard error.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               flush      - clear the count (wins over inc/dec)
//               inc        - an accepted issue targets this register
//               wb_hit     - a writeback targets this register
//               cnt        - current pending count
//               ovf / unf  - issue while full / writeback while empty
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
    parameter int MAX_INFL = 3,
    parameter int CNT_W    = $clog2(MAX_INFL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inc,
    input  logic             wb_hit,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic             unf
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_INFL);

    logic [CNT_W-1:0] r_cnt;
    logic             w_busy;
    logic             w_full;
    logic             w_dec;

    assign w_busy = (r_cnt != '0);
    assign w_full = (r_cnt == C_MAX);
    // A writeback only retires a pending write if one exists.
    assign w_dec  = wb_hit & w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (inc && !w_dec) begin
            if (!w_full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_dec && !inc) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A simultaneous retire frees the slot the new issue takes, so that
    // case is not an overflow. Flush discards the cycle's bookkeeping.
    assign ovf = inc & ~w_dec & w_full & ~flush;
    assign unf = wb_hit & ~w_busy & ~flush;
    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Register file with NRD combinational read ports, writeback
//               bypass, one synchronous write port, hardwired-zero r0 and a
//               per-register pending-write scoreboard that raises a RAW
//               stall for decode.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               rd_addr/rd_data     - packed read ports (port i at slice i)
//               rd_used             - port i is a real source this cycle
//               issue_valid/wen/dst - decode issue request
//               issue_ack, stall    - issue accepted / RAW hazard
//               wb_en/addr/data     - writeback port
//               flush               - clear all pending counts
//               dbg_addr/dbg_data   - raw array read, no bypass
//               sb_err              - sticky overflow/underflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 2,
    parameter int MAX_INFL = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic [NRD-1:0]        rd_used,
    input  logic                  issue_valid,
    input  logic                  issue_wen,
    input  logic [ADDR_W-1:0]     issue_dst,
    output logic                  issue_ack,
    output logic                  stall,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic                  sb_err
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(MAX_INFL + 1);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [CNT_W-1:0]  w_cnt  [NREGS];
    logic [NREGS-1:0]  w_ovf;
    logic [NREGS-1:0]  w_unf;
    logic [NRD-1:0]    w_hazard;
    logic              w_issue_wr;
    logic              r_flush_seen;
    logic              r_sb_err;

    assign w_issue_wr = issue_ack & issue_wen;

    // r0 has no counter; tie its slot to zero so lookups by address stay
    // uniform and a read of r0 can never hazard.
    assign w_cnt[0] = '0;
    assign w_ovf[0] = 1'b0;
    assign w_unf[0] = 1'b0;

    generate
        for (genvar r = 1; r < NREGS; r++) begin : g_cnt
            sb_counter #(
                .MAX_INFL (MAX_INFL),
                .CNT_W    (CNT_W)
            ) u_cnt (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush),
                .inc    (w_issue_wr & (issue_dst == ADDR_W'(r))),
                .wb_hit (wb_en & (wb_addr == ADDR_W'(r))),
                .cnt    (w_cnt[r]),
                .ovf    (w_ovf[r]),
                .unf    (w_unf[r])
            );
        end
    endgenerate

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic              w_wb_match;

            assign w_ra       = rd_addr[i*ADDR_W +: ADDR_W];
            assign w_wb_match = wb_en & (wb_addr == w_ra) & (w_ra != '0);

            assign rd_data[i*DATA_W +: DATA_W] = w_wb_match ? wb_data : r_regs[w_ra];

            // The last outstanding write landing this cycle is served by the
            // bypass, so it does not hold decode.
            assign w_hazard[i] = rd_used[i] & (w_ra != '0) & (w_cnt[w_ra] != '0)
                               & ~(w_wb_match & (w_cnt[w_ra] == CNT_W'(1)));
        end
    endgenerate

    assign stall     = |w_hazard;
    assign issue_ack = issue_valid & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Once any flush has happened, writebacks of squashed instructions may
    // arrive with no pending count, so underflow is no longer an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_seen <= 1'b0;
            r_sb_err     <= 1'b0;
        end else begin
            if (flush) begin
                r_flush_seen <= 1'b1;
            end
            if ((|w_ovf) || ((|w_unf) && !r_flush_seen)) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    assign dbg_data = r_regs[dbg_addr];
    assign sb_err   = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench for regfile_scoreboard: directed vector
//               table for the default build, a short sequence on a 3-port
//               32-bit build, and randomized cycles against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default build: DATA_W 16, ADDR_W 4, NRD 2
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_used;
    logic        issue_valid, issue_wen, issue_ack, stall;
    logic [3:0]  issue_dst;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flush;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        sb_err;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_used(rd_used),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_dst(issue_dst),
        .issue_ack(issue_ack), .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .sb_err(sb_err)
    );

    // wide build: DATA_W 32, ADDR_W 5, NRD 3
    logic [14:0] rd_addr3;
    logic [95:0] rd_data3;
    logic [2:0]  rd_used3;
    logic        issue_valid3, issue_wen3, issue_ack3, stall3;
    logic [4:0]  issue_dst3;
    logic        wb_en3;
    logic [4:0]  wb_addr3;
    logic [31:0] wb_data3;
    logic [4:0]  dbg_addr3;
    logic [31:0] dbg_data3;
    logic        sb_err3;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NRD(3), .MAX_INFL(3)) dut3 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr3), .rd_data(rd_data3), .rd_used(rd_used3),
        .issue_valid(issue_valid3), .issue_wen(issue_wen3), .issue_dst(issue_dst3),
        .issue_ack(issue_ack3), .stall(stall3), .wb_en(wb_en3), .wb_addr(wb_addr3),
        .wb_data(wb_data3), .flush(1'b0), .dbg_addr(dbg_addr3), .dbg_data(dbg_data3),
        .sb_err(sb_err3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, flush, wb_en;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [3:0]  ra0, ra1;
        logic [1:0]  used;
        logic        iv, iw;
        logic [3:0]  idst, dbg;
        logic [15:0] e_rd0, e_rd1;
        logic        e_stall, e_ack, e_err;
        logic [15:0] e_dbg;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic f, input logic we, input logic [3:0] wa,
        input logic [15:0] wd, input logic [3:0] ra0, input logic [3:0] ra1,
        input logic [1:0] used, input logic iv, input logic iw, input logic [3:0] idst,
        input logic [3:0] dbg, input logic [15:0] e0, input logic [15:0] e1,
        input logic es, input logic ea, input logic ee, input logic [15:0] ed);
        vec_t v;
        v.rst = r; v.flush = f; v.wb_en = we; v.wa = wa; v.wd = wd;
        v.ra0 = ra0; v.ra1 = ra1; v.used = used; v.iv = iv; v.iw = iw;
        v.idst = idst; v.dbg = dbg; v.e_rd0 = e0; v.e_rd1 = e1;
        v.e_stall = es; v.e_ack = ea; v.e_err = ee; v.e_dbg = ed;
        return v;
    endfunction

    task automatic apply(input logic r, input logic f, input logic we, input logic [3:0] wa,
                         input logic [15:0] wd, input logic [3:0] ra0, input logic [3:0] ra1,
                         input logic [1:0] used, input logic iv, input logic iw,
                         input logic [3:0] idst, input logic [3:0] dbg);
        rst = r; flush = f; wb_en = we; wb_addr = wa; wb_data = wd;
        rd_addr = {ra1, ra0}; rd_used = used; issue_valid = iv; issue_wen = iw;
        issue_dst = idst; dbg_addr = dbg;
    endtask

    // ---------------- reference model (random phase) ----------------
    logic [15:0] m_regs [16];
    int          m_cnt  [16];
    bit          m_err, m_fseen;

    function automatic logic [15:0] m_rd(input logic [3:0] a);
        if (wb_en && wb_addr == a && a != 0) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_haz(input bit used, input logic [3:0] a);
        if (!used || a == 0 || m_cnt[a] == 0) return 0;
        if (wb_en && wb_addr == a && m_cnt[a] == 1) return 0;
        return 1;
    endfunction

    task automatic m_update(input bit ack);
        int pre [16];
        if (rst) begin
            for (int r = 0; r < 16; r++) begin m_regs[r] = 0; m_cnt[r] = 0; end
            m_err = 0; m_fseen = 0;
            return;
        end
        for (int r = 0; r < 16; r++) pre[r] = m_cnt[r];
        if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
        if (flush) begin
            for (int r = 0; r < 16; r++) m_cnt[r] = 0;
            m_fseen = 1;
        end else begin
            if (wb_en && wb_addr != 0 && pre[wb_addr] == 0 && !m_fseen) m_err = 1;
            for (int r = 1; r < 16; r++) begin
                bit inc, dec;
                inc = ack && issue_wen && issue_dst == r;
                dec = wb_en && wb_addr == r && pre[r] != 0;
                if (inc && !dec) begin
                    if (pre[r] == 3) m_err = 1;
                    else m_cnt[r] = pre[r] + 1;
                end else if (dec && !inc) begin
                    m_cnt[r] = pre[r] - 1;
                end
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        // r3 is written with 0x1234 and later cleared by reset; r5 bypass;
        // r4 RAW; r2 multi in flight; r6/r7 flush.
        tbl.push_back(mk(0,0,1,3,16'h1234, 3,0,0, 0,0,0, 3, 16'h1234,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,        3,0,0, 0,0,0, 3, 16'h1234,0,0,0,1,16'h1234));
        tbl.push_back(mk(1,0,0,0,0,        3,0,0, 0,0,0, 3, 16'h1234,0,0,0,1,16'h1234));
        tbl.push_back(mk(0,0,0,0,0,        3,3,0, 1,0,0, 3, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,        5,0,0, 1,1,5, 0, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,1,5,16'hBEEF, 5,0,1, 0,0,0, 5, 16'hBEEF,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,16'hFFFF, 0,5,0, 0,0,0, 5, 0,16'hBEEF,0,0,0,16'hBEEF));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0, 0,0,0, 0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0, 1,1,4, 0, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,        4,0,1, 1,0,0, 0, 0,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,        4,0,1, 1,0,0, 0, 0,0,1,0,0,0));
        tbl.push_back(mk(0,0,1,4,16'h4444, 4,0,1, 1,0,0, 0, 16'h4444,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,        4,0,1, 0,0,0, 4, 16'h4444,0,0,0,0,16'h4444));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0, 1,1,2, 0, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0, 1,1,2, 0, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0, 1,1,2, 0, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0, 1,1,2, 0, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,1,2,16'h2222, 2,0,1, 0,0,0, 0, 16'h2222,0,1,0,1,0));
        tbl.push_back(mk(0,0,1,2,16'h2223, 2,0,1, 0,0,0, 0, 16'h2223,0,1,0,1,0));
        tbl.push_back(mk(0,0,1,2,16'h2224, 2,0,1, 0,0,0, 0, 16'h2224,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,        2,0,1, 0,0,0, 2, 16'h2224,0,0,0,1,16'h2224));
        tbl.push_back(mk(1,0,0,0,0,        0,0,0, 0,0,0, 0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0, 1,1,6, 0, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,        0,0,0, 1,1,7, 0, 0,0,0,1,0,0));
        tbl.push_back(mk(0,1,0,0,0,        0,0,0, 1,1,6, 0, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,        6,7,3, 1,0,0, 0, 0,0,0,1,0,0));
        tbl.push_back(mk(0,0,1,6,16'h6666, 6,0,1, 0,0,0, 0, 16'h6666,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,        6,0,1, 0,0,0, 6, 16'h6666,0,0,0,0,16'h6666));

        apply(1,0,0,0,0, 0,0,0, 0,0,0, 0);
        rd_addr3 = '0; rd_used3 = '0; issue_valid3 = 0; issue_wen3 = 0; issue_dst3 = '0;
        wb_en3 = 0; wb_addr3 = '0; wb_data3 = '0; dbg_addr3 = '0;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- directed table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            apply(v.rst, v.flush, v.wb_en, v.wa, v.wd, v.ra0, v.ra1, v.used,
                  v.iv, v.iw, v.idst, v.dbg);
            @(negedge clk);
            chk($sformatf("vec%0d rd0", i), {16'h0, rd_data[15:0]},  {16'h0, v.e_rd0});
            chk($sformatf("vec%0d rd1", i), {16'h0, rd_data[31:16]}, {16'h0, v.e_rd1});
            chk($sformatf("vec%0d stall", i), {31'h0, stall},     {31'h0, v.e_stall});
            chk($sformatf("vec%0d ack", i),   {31'h0, issue_ack}, {31'h0, v.e_ack});
            chk($sformatf("vec%0d sb_err", i), {31'h0, sb_err},   {31'h0, v.e_err});
            chk($sformatf("vec%0d dbg", i), {16'h0, dbg_data},    {16'h0, v.e_dbg});
            @(posedge clk);
            #1;
        end
        apply(0,0,0,0,0, 0,0,0, 0,0,0, 0);

        // ---------------- wide build: 3 ports, 32-bit ----------------
        wb_en3 = 1; wb_addr3 = 5'd1; wb_data3 = 32'h1111_1111;
        @(posedge clk); #1;
        wb_addr3 = 5'd31; wb_data3 = 32'hDEAD_BEEF;
        issue_valid3 = 1; issue_wen3 = 1; issue_dst3 = 5'd9;
        @(posedge clk); #1;
        wb_en3 = 0; issue_valid3 = 0; issue_wen3 = 0;
        rd_addr3 = {5'd0, 5'd31, 5'd1}; rd_used3 = 3'b011;
        @(negedge clk);
        chk("w3 rd0", rd_data3[31:0],  32'h1111_1111);
        chk("w3 rd1", rd_data3[63:32], 32'hDEAD_BEEF);
        chk("w3 rd2", rd_data3[95:64], 32'h0);
        chk("w3 nostall", {31'h0, stall3}, 32'h0);
        @(posedge clk); #1;
        rd_addr3 = {5'd9, 5'd31, 5'd1}; rd_used3 = 3'b100; issue_valid3 = 1;
        @(negedge clk);
        chk("w3 port2 stall", {31'h0, stall3}, 32'h1);
        chk("w3 port2 ack", {31'h0, issue_ack3}, 32'h0);
        @(posedge clk); #1;
        issue_valid3 = 0; rd_used3 = '0;

        // ---------------- randomized vs reference model ----------------
        apply(1,0,0,0,0, 0,0,0, 0,0,0, 0);
        @(posedge clk);
        m_update(0);
        #1;
        for (int c = 0; c < 600; c++) begin
            bit ms, ma;
            logic [3:0] a0, a1;
            rst         = ($urandom_range(0, 99) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            wb_en       = ($urandom_range(0, 9) < 4);
            wb_addr     = 4'($urandom_range(0, 7));
            wb_data     = 16'($urandom);
            a0          = 4'($urandom_range(0, 7));
            a1          = 4'($urandom_range(0, 7));
            rd_addr     = {a1, a0};
            rd_used     = 2'($urandom);
            issue_valid = $urandom_range(0, 1) == 1;
            issue_wen   = $urandom_range(0, 3) != 0;
            issue_dst   = 4'($urandom_range(0, 7));
            dbg_addr    = 4'($urandom_range(0, 15));
            ms = m_haz(rd_used[0], a0) || m_haz(rd_used[1], a1);
            ma = issue_valid && !ms;
            @(negedge clk);
            chk("rnd rd0", {16'h0, rd_data[15:0]},  {16'h0, m_rd(a0)});
            chk("rnd rd1", {16'h0, rd_data[31:16]}, {16'h0, m_rd(a1)});
            chk("rnd stall", {31'h0, stall},        {31'h0, ms});
            chk("rnd ack", {31'h0, issue_ack},      {31'h0, ma});
            chk("rnd sb_err", {31'h0, sb_err},      {31'h0, m_err});
            chk("rnd dbg", {16'h0, dbg_data},       {16'h0, m_regs[dbg_addr]});
            @(posedge clk);
            m_update(ma);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the pipelined 16-bit MIPS datapath, with a per-register pending-write scoreboard. It provides NRD combinational read ports with writeback-to-read bypass and one synchronous write port, and keeps a hardwired-zero register. It also raises a RAW-hazard stall when a read source has an in-flight write, so decode can hold. Reads sit in ID, writes in WB, and `flush` is driven by branch/jump resolution.

## Interface
- `DATA_W`, 16: register width.
- `ADDR_W`, 4: register address width; NREGS = 2**ADDR_W.
- `NRD`, 2: number of read ports.
- `MAX_INFL`, 3: maximum in-flight writes per register (ID-to-WB distance). Counter width is clog2(MAX_INFL+1).
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `rd_addr`, in, NRD*ADDR_W: packed read addresses; port i is at bits [i*ADDR_W +: ADDR_W].
- `rd_data`, out, NRD*DATA_W: packed read data, same packing as `rd_addr`.
- `rd_used`, in, NRD: port i is a real source this cycle; only used ports can stall.
- `issue_valid`, in, 1: decode wants to issue an instruction.
- `issue_wen`, in, 1: the issuing instruction writes a register.
- `issue_dst`, in, ADDR_W: destination register of the issuing instruction.
- `issue_ack`, out, 1: issue accepted, equal to issue_valid & ~stall.
- `stall`, out, 1: RAW hazard on at least one used read port.
- `wb_en`, in, 1: writeback enable.
- `wb_addr`, in, ADDR_W: writeback register.
- `wb_data`, in, DATA_W: writeback data.
- `flush`, in, 1: clear all pending counts.
- `dbg_addr`, in, ADDR_W: debug read address.
- `dbg_data`, out, DATA_W: debug read data (raw array contents, no bypass).
- `sb_err`, out, 1: sticky error flag, set on scoreboard overflow or underflow.

## Operation
- **Register 0:** reads 0 on every port. Writes to it are dropped. Issues to it are never counted.
- **Reads (combinational):**
  - rd_data[i] = wb_data when wb_en, wb_addr == rd_addr[i], and rd_addr[i] != 0.
  - Otherwise rd_data[i] = regs[rd_addr[i]].
- **Writes:** when wb_en and wb_addr != 0, regs[wb_addr] <= wb_data at the clock edge.
- **Pending count:** each register r has a counter cnt[r].
  - inc = issue_ack & issue_wen & (issue_dst == r) & (r != 0).
  - dec = wb_en & (wb_addr == r) & (cnt[r] != 0).
  - inc and dec together leave cnt unchanged.
  - inc when cnt == MAX_INFL saturates the counter and sets sb_err.
  - wb_en when cnt == 0 writes data normally, does not decrement, and sets sb_err, unless flush was asserted at any point since the last reset.
- **Hazard:** port i is hazarded when rd_used[i], rd_addr[i] != 0, cnt[rd_addr[i]] != 0, and not (wb_en & wb_addr == rd_addr[i] & cnt == 1).
  - The last in-flight write landing this cycle is covered by the bypass.
  - stall = OR over all ports of hazard[i].
- **Flush:** every cnt is set to 0 next cycle. Flush has priority over same-cycle inc/dec. The register array is unaffected.
- **Reset:** all registers, all counters, sb_err, and the flush-seen flag clear to 0.
  - Outputs after reset: rd_data = 0, dbg_data = 0, stall = 0, issue_ack = issue_valid, sb_err = 0.
  - rst has priority over wb_en, issue, and flush in the same cycle.

## Timing
- Read latency is 0 cycles; write-to-read through the array is 1 cycle; bypass makes same-cycle writeback visible.
- stall and issue_ack are combinational from the current counters and inputs. There is no combinational path from stall to the counters except through issue_ack.
- A counter changed at edge n affects stall from cycle n+1.
- When reset deasserts, the first cycle is fully operational.

## Structure
- Shared package `cpu_pkg`: DATA_W and ADDR_W defaults, the ZERO_REG constant, and the `reg_addr_t` / `word_t` typedefs used by decode and WB.
- Sub-module `sb_counter` holds one saturating up/down counter with flush and overflow/underflow pulses. It is instantiated NREGS-1 times with a generate loop; register 0 has no counter.
- The array is a plain reg vector with no RAM inference requirement.

## Test plan
- **Reset:** write r3 = 0x1234, assert rst for 1 cycle. All rd_data and dbg_data read 0x0000; stall = 0; sb_err = 0.
- **Bypass:** wb_en, wb_addr = 5, wb_data = 0xBEEF, rd_addr0 = 5 in the same cycle. rd_data0 = 0xBEEF in that cycle; dbg_data(5) = 0xBEEF next cycle. Repeating with wb_addr = 0 leaves r0 = 0.
- **RAW stall:** issue dst = 4, then rd_used0 with rd_addr0 = 4. stall = 1 and issue_ack = 0 until the cycle wb_addr = 4 arrives; in that cycle stall = 0 and rd_data0 = wb_data.
- **Multiple in flight:**
  - Issue dst = 2 three times; cnt = 3.
  - A fourth issue saturates the counter and sets sb_err.
  - Two writebacks leave stall = 1 on r2; the third clears it via bypass.
- **Flush:**
  - Issue dst = 6 and dst = 7, then flush. Next cycle no stall on r6/r7.
  - A late wb to r6 writes data without raising sb_err.
  - A simultaneous issue dst = 6 during flush is dropped (cnt = 0).
- **Parametrised build:** NRD = 3, DATA_W = 32, ADDR_W = 5. Three ports read distinct registers 1, 31, 0 → correct data, 0 on the r0 port; a hazard on port 2 alone asserts stall.
